instr_prefetch_queue: RTL and testbench

//  Fetch front-end that sits directly upstream of the IF/ID pipeline register.
//  It owns the fetch PC and issues one-at-a-time requests to a variable-latency

---
 rtl/instr_prefetch_queue_pkg.sv | 10 +
 rtl/instr_prefetch_queue_fetch_fifo.sv | 43 ++++
 rtl/instr_prefetch_queue.sv | 61 ++++++
 tb/tb_instr_prefetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: shared constants and the queue entry layout for the fetch front-end
package instr_prefetch_queue_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// instr_prefetch_queue_fetch_fifo: synchronous 64-bit FIFO with flush, holding fetched {pc+4, instr} pairs
module instr_prefetch_queue_fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [63:0]                wdata,
    output logic [63:0]                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    // Storage needs no reset: the head is only observed when the FIFO is non-empty.
    always_ff @(posedge clk_i)
        if (do_push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch PC owner issuing single-outstanding imem requests into a prefetch FIFO
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [31:0]   fetch_pc, req_addr;
    logic          pending, drop, fire, push, pop, full, empty;
    logic [CW-1:0] count;
    logic [63:0]   head;
    fetch_entry_t  wentry;
    // Gating with rst_i keeps req low for the whole time reset is asserted.
    assign imem_req_o    = rst_i && (pending || (count < CW'(DEPTH) && !redirect_i));
    // An outstanding request keeps its original address even after a redirect moves fetch_pc.
    assign imem_addr_o   = pending ? req_addr : fetch_pc;
    assign fire          = imem_req_o && imem_ack_i;
    assign push          = fire && !drop && !redirect_i && !full;
    assign pop           = !empty && !stall_i;
    assign wentry        = '{pc_plus4: fetch_pc + PC_STEP, instr: imem_data_i};
    assign instr_valid_o = !empty;
    assign {pc_plus4_o, instr_o} = empty ? {32'h0, NOP_INSTR} : head;
    instr_prefetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            pending  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            fetch_pc <= redirect_i ? redirect_pc_i : push ? fetch_pc + PC_STEP : fetch_pc;
            req_addr <= imem_addr_o;
            pending  <= imem_req_o && !imem_ack_i;
            drop     <= !fire && (drop || (redirect_i && pending));
        end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: table-driven and directed checks of the prefetch queue against a latency-programmable memory
module tb_instr_prefetch_queue;
    logic        clk_i = 1'b0, rst_i = 1'b0, redirect_i = 1'b0, stall_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o, imem_ack_i, instr_valid_o;
    logic [31:0] imem_addr_o, imem_data_i, instr_o, pc_plus4_o;
    int          lat = 0, wcnt = 0, checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    // Memory model: ack once the request has waited lat cycles; word is ~address.
    assign imem_ack_i  = imem_req_o && (wcnt >= lat);
    assign imem_data_i = ~imem_addr_o;
    always @(posedge clk_i) wcnt <= (!imem_req_o || imem_ack_i) ? 0 : wcnt + 1;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    typedef struct {
        logic        rs;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc4;
    } vec_t;
    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic valid, input logic [31:0] pc4);
        logic [31:0] ei;
        ei = valid ? ~(pc4 - 32'd4) : 32'h0;
        chk({tag, ".valid"}, {31'h0, instr_valid_o}, {31'h0, valid});
        chk({tag, ".pc4"}, pc_plus4_o, valid ? pc4 : 32'h0);
        chk({tag, ".instr"}, instr_o, ei);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        stall_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        int n;
        // zero-wait streaming, then stall until full and drain in order
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 32'h04};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h08};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h0c, 1'b1, 32'h0c};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h10};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h04};
        for (int i = 9; i < 15; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h04};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h04};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0c};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};

        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.req", {31'h0, imem_req_o}, 32'h0);
        chk("reset.addr", imem_addr_o, 32'h0);
        chk_out("reset", 1'b0, 32'h0);

        lat = 0;
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rs) do_reset();
            else step();
            stall_i = vecs[i].stall;
            @(negedge clk_i);
            chk($sformatf("vec%0d.req", i), {31'h0, imem_req_o}, {31'h0, vecs[i].req});
            chk($sformatf("vec%0d.addr", i), imem_addr_o, vecs[i].addr);
            chk_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc4);
        end

        // 3-cycle memory: address held, one word every 4 cycles, NOP between
        lat = 3;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) step();
            @(negedge clk_i);
            chk($sformatf("slow%0d.req", c), {31'h0, imem_req_o}, 32'h1);
            chk($sformatf("slow%0d.addr", c), imem_addr_o, 32'((c / 4) * 4));
            chk_out($sformatf("slow%0d", c), c > 0 && c % 4 == 0, 32'(c));
        end

        // redirect while the request at 0x8 is pending: its ack must be dropped
        do_reset();
        repeat (8) step();
        @(negedge clk_i);
        chk("rd.pre_addr", imem_addr_o, 32'h8);
        chk_out("rd.pre", 1'b1, 32'h8);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        @(negedge clk_i);
        chk("rd.hold_addr", imem_addr_o, 32'h8);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk("rd.drop_req", {31'h0, imem_req_o}, 32'h1);
        chk("rd.drop_addr", imem_addr_o, 32'h8);
        chk_out("rd.flushed", 1'b0, 32'h0);
        step();
        @(negedge clk_i);
        chk("rd.old_ack", {31'h0, imem_ack_i}, 32'h1);
        step();
        @(negedge clk_i);
        chk("rd.new_addr", imem_addr_o, 32'h40);
        chk_out("rd.after_drop", 1'b0, 32'h0);
        n = 0;
        do begin
            step();
            @(negedge clk_i);
            n++;
        end while (!instr_valid_o && n < 20);
        chk("rd.wait_cycles", 32'(n), 32'd4);
        chk_out("rd.first", 1'b1, 32'h44);

        // redirect coinciding with an ack while stalled
        lat = 1;
        do_reset();
        stall_i = 1'b1;
        repeat (2) step();
        @(negedge clk_i);
        chk_out("rs.pre", 1'b1, 32'h4);
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk_i);
        chk("rs.ack", {31'h0, imem_ack_i}, 32'h1);
        step();
        redirect_i = 1'b0;
        @(negedge clk_i);
        chk_out("rs.empty", 1'b0, 32'h0);
        chk("rs.addr", imem_addr_o, 32'h100);
        chk("rs.req", {31'h0, imem_req_o}, 32'h1);
        repeat (2) step();
        @(negedge clk_i);
        chk_out("rs.target", 1'b1, 32'h104);

        // asynchronous reset mid-request with two words buffered
        do_reset();
        stall_i = 1'b1;
        repeat (4) step();
        @(negedge clk_i);
        chk_out("ar.pre", 1'b1, 32'h4);
        chk("ar.pre_addr", imem_addr_o, 32'h8);
        #2 rst_i = 1'b0;
        #1;
        chk("ar.req", {31'h0, imem_req_o}, 32'h0);
        chk("ar.addr", imem_addr_o, 32'h0);
        chk_out("ar.out", 1'b0, 32'h0);
        step();
        rst_i   = 1'b1;
        stall_i = 1'b0;
        @(negedge clk_i);
        chk("ar.restart_req", {31'h0, imem_req_o}, 32'h1);
        chk("ar.restart_addr", imem_addr_o, 32'h0);
        repeat (2) step();
        @(negedge clk_i);
        chk_out("ar.first", 1'b1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
